// File: rtl/dip_led_if.sv
// Switch/LED bundle between the board pins and the DIP/LED controller.
// The master side drives the switch levels and the mode; the slave side drives the LEDs and status.
interface dip_led_if #(
   parameter int N_SW = 24
);
   logic [N_SW-1:0] io_dip;
   logic [1:0]      mode;
   logic [N_SW-1:0] io_led;
   logic [N_SW-1:0] sw_db;
   logic            change;

   modport master (
      output io_dip,
      output mode,
      input  io_led,
      input  sw_db,
      input  change
   );

   modport slave (
      input  io_dip,
      input  mode,
      output io_led,
      output sw_db,
      output change
   );
endinterface

// File: rtl/dip_led_ctrl.sv
// Synchronises and debounces N_SW DIP switches, then drives the LEDs in one of four modes:
// pass-through, toggle-latch, rising-edge count or blink.
module dip_led_ctrl #(
   parameter int N_SW            = 24,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLINK_DIV       = 25000000
) (
   input logic       clk,
   input logic       rst_n,
   dip_led_if.slave  bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = $clog2(BLINK_DIV + 1);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 1);

   function automatic logic [N_SW-1:0] popcount(input logic [N_SW-1:0] v);
      logic [N_SW-1:0] acc;
      acc = '0;
      for (int i = 0; i < N_SW; i++) begin
         acc = acc + N_SW'(v[i]);
      end
      return acc;
   endfunction

   logic [N_SW-1:0] sync1_q, sync1_d;
   logic [N_SW-1:0] sync2_q, sync2_d;
   logic [N_SW-1:0] sw_db_q, sw_db_d;
   logic [CW-1:0]   db_cnt_q [N_SW];
   logic [CW-1:0]   db_cnt_d [N_SW];
   logic            change_q, change_d;
   logic [N_SW-1:0] tog_q, tog_d;
   logic [N_SW-1:0] cnt_q, cnt_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic            phase_q, phase_d;
   logic [N_SW-1:0] led_q, led_d;
   logic [N_SW-1:0] accept_s;
   logic [N_SW-1:0] rise_s;

   // Next-state logic: debounce, event derivation, toggle/count/blink state and LED mux.
   always_comb begin
      sync1_d  = bus.io_dip;
      sync2_d  = sync1_q;
      accept_s = '0;
      for (int i = 0; i < N_SW; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != sw_db_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               accept_s[i] = 1'b1;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + CW'(1);
            end
         end else begin
            db_cnt_d[i] = '0;
         end
      end

      // An accept always flips the debounced bit, since sync and sw_db differ there.
      sw_db_d  = sw_db_q ^ accept_s;
      rise_s   = accept_s & sync2_q;
      change_d = |accept_s;
      tog_d    = tog_q ^ rise_s;
      cnt_d    = cnt_q + popcount(rise_s);

      if (pre_q == PRE_LAST) begin
         pre_d   = '0;
         phase_d = ~phase_q;
      end else begin
         pre_d   = pre_q + PW'(1);
         phase_d = phase_q;
      end

      case (bus.mode)
         2'd0:    led_d = sw_db_q;
         2'd1:    led_d = tog_q;
         2'd2:    led_d = cnt_q;
         2'd3:    led_d = sw_db_q & {N_SW{phase_q}};
         default: led_d = '0;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         sw_db_q  <= '0;
         change_q <= 1'b0;
         tog_q    <= '0;
         cnt_q    <= '0;
         pre_q    <= '0;
         phase_q  <= 1'b1;
         led_q    <= '0;
         for (int i = 0; i < N_SW; i++) begin
            db_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         sw_db_q  <= sw_db_d;
         change_q <= change_d;
         tog_q    <= tog_d;
         cnt_q    <= cnt_d;
         pre_q    <= pre_d;
         phase_q  <= phase_d;
         led_q    <= led_d;
         for (int i = 0; i < N_SW; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
      end
   end

   assign bus.io_led = led_q;
   assign bus.sw_db  = sw_db_q;
   assign bus.change = change_q;

endmodule

// File: tb/tb_dip_led_ctrl.sv
// Directed bench for dip_led_ctrl with N_SW=4, DEBOUNCE_CYCLES=4, BLINK_DIV=3.
module tb_dip_led_ctrl;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   dip_led_if #(.N_SW(4)) bus ();

   dip_led_ctrl #(
      .N_SW(4),
      .DEBOUNCE_CYCLES(4),
      .BLINK_DIV(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] dip;
      logic [1:0] mode;
      logic [3:0] led;
      logic [3:0] db;
      logic       chg;
   } vec_t;

   vec_t tv [22];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      bus.io_dip = 4'h0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Holds a level for 7 edges: accepted on the 6th, visible on io_led after the 7th.
   task automatic apply_level(input logic [3:0] v, output int pulses);
      bus.io_dip = v;
      pulses     = 0;
      repeat (7) begin
         tick();
         if (bus.change === 1'b1) pulses++;
      end
   endtask

   logic [3:0] rej_pat [13];
   logic [3:0] tog_exp [6];
   int p;

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      bus.io_dip = 4'h0;
      bus.mode   = 2'd0;

      // Reset with switches high, release, debounce, then walk through the modes.
      tv[0]  = '{1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 1'b0};
      tv[1]  = '{1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 1'b0};
      tv[2]  = '{1'b0, 4'hF, 2'd0, 4'h0, 4'h0, 1'b0};
      tv[3]  = '{1'b1, 4'hF, 2'd0, 4'h0, 4'h0, 1'b0};
      tv[4]  = '{1'b1, 4'hF, 2'd0, 4'h0, 4'h0, 1'b0};
      tv[5]  = '{1'b1, 4'hF, 2'd0, 4'h0, 4'h0, 1'b0};
      tv[6]  = '{1'b1, 4'hF, 2'd0, 4'h0, 4'h0, 1'b0};
      tv[7]  = '{1'b1, 4'hF, 2'd0, 4'h0, 4'h0, 1'b0};
      tv[8]  = '{1'b1, 4'hF, 2'd0, 4'h0, 4'hF, 1'b1};
      tv[9]  = '{1'b1, 4'hF, 2'd0, 4'hF, 4'hF, 1'b0};
      tv[10] = '{1'b1, 4'hF, 2'd1, 4'hF, 4'hF, 1'b0};
      tv[11] = '{1'b1, 4'hF, 2'd2, 4'h4, 4'hF, 1'b0};
      tv[12] = '{1'b1, 4'hF, 2'd3, 4'h0, 4'hF, 1'b0};
      tv[13] = '{1'b1, 4'hF, 2'd3, 4'h0, 4'hF, 1'b0};
      tv[14] = '{1'b1, 4'hF, 2'd3, 4'h0, 4'hF, 1'b0};
      tv[15] = '{1'b1, 4'hF, 2'd3, 4'hF, 4'hF, 1'b0};
      tv[16] = '{1'b1, 4'hF, 2'd3, 4'hF, 4'hF, 1'b0};
      tv[17] = '{1'b1, 4'hF, 2'd3, 4'hF, 4'hF, 1'b0};
      tv[18] = '{1'b1, 4'hF, 2'd3, 4'h0, 4'hF, 1'b0};
      tv[19] = '{1'b1, 4'hF, 2'd0, 4'hF, 4'hF, 1'b0};
      tv[20] = '{1'b1, 4'hF, 2'd2, 4'h4, 4'hF, 1'b0};
      tv[21] = '{1'b1, 4'hF, 2'd1, 4'hF, 4'hF, 1'b0};

      for (int i = 0; i < 22; i++) begin
         rst_n      = tv[i].rst_n;
         bus.io_dip = tv[i].dip;
         bus.mode   = tv[i].mode;
         tick();
         chk($sformatf("vec%0d io_led", i), 32'(bus.io_led), 32'(tv[i].led));
         chk($sformatf("vec%0d sw_db", i),  32'(bus.sw_db),  32'(tv[i].db));
         chk($sformatf("vec%0d change", i), 32'(bus.change), 32'(tv[i].chg));
      end

      // Debounce reject: bounces shorter than the window never reach sw_db.
      do_reset();
      bus.mode = 2'd0;
      rej_pat = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      for (int i = 0; i < 13; i++) begin
         bus.io_dip = rej_pat[i];
         tick();
         chk($sformatf("reject%0d sw_db", i),  32'(bus.sw_db),  32'h0);
         chk($sformatf("reject%0d change", i), 32'(bus.change), 32'h0);
      end
      bus.io_dip = 4'h1;
      repeat (5) tick();
      chk("hold5 sw_db early", 32'(bus.sw_db), 32'h0);
      tick();
      chk("hold5 sw_db", 32'(bus.sw_db), 32'h1);
      chk("hold5 change", 32'(bus.change), 32'h1);
      chk("hold5 io_led lag", 32'(bus.io_led), 32'h0);
      tick();
      chk("hold5 io_led", 32'(bus.io_led), 32'h1);
      chk("hold5 change drop", 32'(bus.change), 32'h0);

      // Toggle: presses on bit 2 flip the LED, releases leave it alone.
      do_reset();
      bus.mode = 2'd1;
      tog_exp = '{4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h4};
      for (int i = 0; i < 6; i++) begin
         apply_level((i % 2 == 0) ? 4'h4 : 4'h0, p);
         chk($sformatf("toggle%0d io_led", i), 32'(bus.io_led), 32'(tog_exp[i]));
      end

      // Count: 17 rises on bit 0 wrap the 4-bit counter.
      do_reset();
      bus.mode = 2'd2;
      for (int i = 1; i <= 17; i++) begin
         apply_level(4'h1, p);
         chk($sformatf("count%0d io_led", i), 32'(bus.io_led), 32'(i % 16));
         apply_level(4'h0, p);
      end

      // Four simultaneous rises from 0xE add 4 and give one change pulse.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         apply_level(4'h1, p);
         apply_level(4'h0, p);
      end
      chk("count preload", 32'(bus.io_led), 32'hE);
      apply_level(4'hF, p);
      chk("count multi-rise", 32'(bus.io_led), 32'h2);
      chk("multi-rise pulses", 32'(p), 32'd1);

      // Reset mid-debounce with cnt=5, then re-debounce from zero.
      do_reset();
      chk("post-reset io_led", 32'(bus.io_led), 32'h0);
      for (int i = 0; i < 5; i++) begin
         apply_level(4'h1, p);
         apply_level(4'h0, p);
      end
      chk("midrst cnt5", 32'(bus.io_led), 32'h5);
      bus.io_dip = 4'h1;
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      chk("midrst io_led", 32'(bus.io_led), 32'h0);
      chk("midrst sw_db", 32'(bus.sw_db), 32'h0);
      chk("midrst change", 32'(bus.change), 32'h0);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("midrst redebounce early", 32'(bus.sw_db), 32'h0);
      tick();
      chk("midrst redebounce sw_db", 32'(bus.sw_db), 32'h1);
      chk("midrst redebounce change", 32'(bus.change), 32'h1);
      tick();
      chk("midrst cnt restart", 32'(bus.io_led), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dip_led_ctrl.md
Name: dip_led_ctrl

Overview:
- Parametrised successor to the board-level DIP-to-LED tie-off.
- Synchronises and debounces N_SW slide switches, then drives N_SW LEDs in one of four runtime-selected modes: pass-through, toggle-latch, edge-count and blink.
- Sits between the Io board DIP pins and the Io/Au LED pins in lab top levels.
- Also exports the clean switch vector and a change strobe for downstream lab logic.

Parameters:
- N_SW, 24, number of switch inputs and LED outputs (1..32).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new switch level (>=1; 10 ms at 100 MHz).
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=1; 4 Hz toggle rate at 100 MHz).

Ports:
- clk  input  1  100 MHz onboard clock
- rst_n  input  1  synchronous reset, active-low
- io_dip  input  N_SW  raw asynchronous DIP switch levels
- mode  input  2  display mode: 0 pass, 1 toggle, 2 count, 3 blink
- io_led  output  N_SW  registered LED drive
- sw_db  output  N_SW  debounced switch levels
- change  output  1  one-cycle pulse when any sw_db bit changes

Behaviour:
- Reset (rst_n low at a clk edge):
  - Clears the sync flops, sw_db, all debounce counters, toggle state, edge counter and prescaler.
  - Sets blink phase to 1.
  - io_led=0, sw_db=0, change=0.
  - Reset mid-debounce abandons the pending change.
- Synchroniser: two flops per bit, giving sync[i].
- Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES+1):
  - If sync[i]==sw_db[i], counter <= 0.
  - Else, if counter==DEBOUNCE_CYCLES-1, sw_db[i] <= sync[i] and counter <= 0.
  - Else counter increments.
  - Any bounce back to the old level restarts the count.
- Latency: a raw level first sampled at edge k appears on sw_db after edge k+1+DEBOUNCE_CYCLES.
- Events:
  - rise[i] = sync[i] & ~sw_db[i] at the accepting edge.
  - change is registered and equals the OR of all per-bit accepts in that cycle.
  - change is high exactly 1 cycle per accepting edge.
  - Simultaneous accepts on several bits produce one pulse.
- Toggle state tog[N_SW-1:0]: bit i inverts on each accepted rising edge of bit i; falling edges are ignored.
- Edge counter cnt[N_SW-1:0]:
  - Adds popcount of rising accepts in that cycle.
  - Wraps modulo 2^N_SW.
  - Multiple simultaneous rises add their full count.
- Blink:
  - Prescaler counts 0..BLINK_DIV-1.
  - Phase inverts on the wrap edge.
- io_led is registered; it reflects the state one edge after the update:
  - mode 0: sw_db
  - mode 1: tog
  - mode 2: cnt
  - mode 3: sw_db & {N_SW{phase}}
- Mode behaviour:
  - mode is sampled every edge; no handshake.
  - A change of mode takes effect on io_led at the next edge.
  - tog, cnt and blink keep running in every mode and are never cleared by a mode change.
- Switches already high at reset release are accepted as rising edges after the normal latency: they pulse change, toggle tog and increment cnt.

Test Plan:
Common configuration: N_SW=4, DEBOUNCE_CYCLES=4, BLINK_DIV=3, clean sync reset, all io_dip=0 unless stated.
- Reset: hold rst_n low 3 edges with io_dip=4'hF -> io_led=0, sw_db=0, change=0 throughout; release and hold io_dip=4'hF -> sw_db=4'hF 5 edges after first sample, one change pulse.
- Debounce reject: mode 0, io_dip[0] high 3 cycles, low 1, high 3, then low -> sw_db[0] never rises, change never pulses. Holding io_dip[0] high 5 cycles -> sw_db[0]=1, io_led=4'h1 one edge later.
- Toggle: mode 1, three clean press/release cycles on bit 2 -> io_led goes 4'h4, 4'h0, 4'h4; releases cause no change in io_led.
- Count wrap: mode 2, 17 rising accepts on bit 0 -> io_led counts 1..15, 0, 1. Simultaneous accept of bits 0..3 from cnt=4'hE -> cnt=4'h2.
- Blink: mode 3, sw_db=4'hA -> io_led alternates 4'hA / 4'h0 every 3 cycles. Switching to mode 0 -> 4'hA next edge. Switching back to mode 1 -> io_led shows the retained tog value.
- Reset mid-operation: assert rst_n low for 1 edge while the debounce counter is at 2 and cnt=4'h5 -> all state cleared; the pending edge is re-debounced from zero after release.
